// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the rhythm-game scoring engine:
//   - judgement grade encoding carried on hit_grade (2 bits per lane)
//   - game-session FSM state encoding
//   - base_points(): base points awarded for a grade
//   - tier_mult(): tiered combo multiplier for a post-increment combo value
// ---------------------------------------------------------------------------
package score_pkg;

   localparam logic [1:0] GRADE_MISS       = 2'b00;
   localparam logic [1:0] GRADE_GOOD_EARLY = 2'b01;
   localparam logic [1:0] GRADE_GOOD_LATE  = 2'b10;
   localparam logic [1:0] GRADE_PERFECT    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Both GOOD grades score the same; MISS scores nothing.
   function automatic int unsigned base_points(input logic [1:0] grade,
                                               input int unsigned pts_good,
                                               input int unsigned pts_perfect);
      int unsigned pts;
      case (grade)
         GRADE_PERFECT:                    pts = pts_perfect;
         GRADE_GOOD_EARLY, GRADE_GOOD_LATE: pts = pts_good;
         default:                          pts = 0;
      endcase
      return pts;
   endfunction

   // The first tier (combo 1..2^tier_shift) already earns x2; every further
   // block of 2^tier_shift hits adds one more step, up to max_mult.
   function automatic logic [4:0] tier_mult(input int unsigned combo,
                                            input int unsigned tier_shift,
                                            input int unsigned max_mult);
      int unsigned m;
      if (combo == 0) m = 1;
      else            m = 2 + ((combo - 1) >> tier_shift);
      if (m > max_mult) m = max_mult;
      return m[4:0];
   endfunction

endpackage

// File: rtl/score_combo_chain.sv
// ---------------------------------------------------------------------------
// score_combo_chain
// Purely combinational per-lane judgement chain. Lanes are walked 0..LANES-1
// and each lane sees the combo as left by the lane before it.
// Ports:
//   combo_in   current registered combo
//   mult_in    current registered multiplier (kept if no non-miss lane)
//   hit_valid  per-lane strobe (already gated by the session state)
//   hit_grade  per-lane grade, lane i at [2i+1:2i]
//   combo_out  combo after the last lane
//   max_out    largest combo seen anywhere in the chain (incl. combo_in)
//   mult_out   multiplier of the last non-miss lane
//   add_sum    sum of all lane adds (base points * multiplier)
//   miss_cnt   number of valid MISS lanes
// ---------------------------------------------------------------------------
module score_combo_chain
   import score_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int COMBO_W     = 8,
   parameter int SUM_W       = 23,
   parameter int TIER_SHIFT  = 4,
   parameter int MAX_MULT    = 17,
   parameter int PTS_GOOD    = 32,
   parameter int PTS_PERFECT = 256,
   parameter int MISS_W      = $clog2(LANES + 1)
) (
   input  logic [COMBO_W-1:0] combo_in,
   input  logic [4:0]         mult_in,
   input  logic [LANES-1:0]   hit_valid,
   input  logic [2*LANES-1:0] hit_grade,
   output logic [COMBO_W-1:0] combo_out,
   output logic [COMBO_W-1:0] max_out,
   output logic [4:0]         mult_out,
   output logic [SUM_W-1:0]   add_sum,
   output logic [MISS_W-1:0]  miss_cnt
);

   localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

   logic [COMBO_W-1:0] c;
   logic [1:0]         g;

   // Walk the lanes in order, carrying the combo from lane to lane. The
   // running max is tracked per lane because a MISS later in the same cycle
   // can wipe out a combo peak that must still reach max_combo.
   always_comb begin
      c        = combo_in;
      g        = GRADE_MISS;
      max_out  = combo_in;
      mult_out = mult_in;
      add_sum  = '0;
      miss_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         g = hit_grade[2*i +: 2];
         if (hit_valid[i]) begin
            if (g == GRADE_MISS) begin
               c        = '0;
               miss_cnt = miss_cnt + MISS_W'(1);
            end else begin
               if (c != COMBO_MAX) c = c + COMBO_W'(1);
               mult_out = tier_mult(32'(c), TIER_SHIFT, MAX_MULT);
               add_sum  = add_sum + SUM_W'(base_points(g, PTS_GOOD, PTS_PERFECT) * 32'(mult_out));
            end
            if (c > max_out) max_out = c;
         end
      end
      combo_out = c;
   end

endmodule

// File: rtl/score_engine.sv
// ---------------------------------------------------------------------------
// score_engine
// Multi-lane scoring engine: session FSM, two-stage pipeline and saturating
// score accumulator. Stage 1 registers combo/max_combo/multiplier and the
// summed lane adds; stage 2 folds that sum into the score.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start, stop  session control pulses (start wins when both are set)
//   hit_valid    per-lane judgement strobe
//   hit_grade    per-lane grade, lane i at [2i+1:2i]
//   score        accumulated score, saturates at 2^SCORE_W-1
//   combo        current combo; max_combo highest combo this session
//   multiplier   multiplier applied to the most recent non-miss hit
//   score_sat    sticky flag: score clamped this session
//   playing      session in PLAY; done session finished and drained
// Build option: define SCORE_MISS_PENALTY_EN to make every MISS lane cost
// PTS_GOOD points in stage 2 (score floored at 0).
// ---------------------------------------------------------------------------
module score_engine
   import score_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int SCORE_W     = 16,
   parameter int COMBO_W     = 8,
   parameter int TIER_SHIFT  = 4,
   parameter int MAX_MULT    = 17,
   parameter int PTS_GOOD    = 32,
   parameter int PTS_PERFECT = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [LANES-1:0]     hit_valid,
   input  logic [2*LANES-1:0]   hit_grade,
   output logic [SCORE_W-1:0]   score,
   output logic [COMBO_W-1:0]   combo,
   output logic [COMBO_W-1:0]   max_combo,
   output logic [4:0]           multiplier,
   output logic                 score_sat,
   output logic                 playing,
   output logic                 done
);

   localparam int SUM_W  = SCORE_W + $clog2(LANES) + 5;
   localparam int MISS_W = $clog2(LANES + 1);
   localparam logic [SUM_W:0] SCORE_MAX = {1'b0, {(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

`ifdef SCORE_MISS_PENALTY_EN
   localparam int PEN_PTS = PTS_GOOD;
`else
   localparam int PEN_PTS = 0;
`endif

   state_t state, next_state;

   logic               accept;
   logic [COMBO_W-1:0] chain_combo, chain_max;
   logic [4:0]         chain_mult;
   logic [SUM_W-1:0]   chain_sum;
   logic [MISS_W-1:0]  chain_miss;

   logic               s1_valid;
   logic [SUM_W-1:0]   s1_sum;
   logic [MISS_W-1:0]  s1_miss;

   logic [SUM_W:0]     total_raw, penalty, total_net;
   logic               clamp_hi;
   logic [SCORE_W-1:0] next_score;

   // Hits only count while playing, and not in a cycle where start or stop
   // is being taken: start throws the session away, stop closes it.
   assign accept  = (state == ST_PLAY) && !start && !stop;
   assign playing = (state == ST_PLAY);
   assign done    = (state == ST_DONE);

   score_combo_chain #(
      .LANES      (LANES),
      .COMBO_W    (COMBO_W),
      .SUM_W      (SUM_W),
      .TIER_SHIFT (TIER_SHIFT),
      .MAX_MULT   (MAX_MULT),
      .PTS_GOOD   (PTS_GOOD),
      .PTS_PERFECT(PTS_PERFECT),
      .MISS_W     (MISS_W)
   ) u_chain (
      .combo_in (combo),
      .mult_in  (multiplier),
      .hit_valid(hit_valid & {LANES{accept}}),
      .hit_grade(hit_grade),
      .combo_out(chain_combo),
      .max_out  (chain_max),
      .mult_out (chain_mult),
      .add_sum  (chain_sum),
      .miss_cnt (chain_miss)
   );

   // Session FSM. DRAIN waits only for the stage-1 slot to empty, because
   // stage 2 lands on the same edge that retires stage 1.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = ST_PLAY;
         ST_PLAY:  if (start) next_state = ST_PLAY;
                   else if (stop) next_state = ST_DRAIN;
         ST_DRAIN: if (start) next_state = ST_PLAY;
                   else if (!s1_valid) next_state = ST_DONE;
         ST_DONE:  if (start) next_state = ST_PLAY;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Stage-2 arithmetic: add the stage-1 sum, take away any miss penalty
   // (never below zero), then clamp at the top of the score range.
   always_comb begin
      total_raw  = (SUM_W+1)'(score) + (SUM_W+1)'(s1_sum);
      penalty    = (SUM_W+1)'(s1_miss) * (SUM_W+1)'(PEN_PTS);
      total_net  = (penalty > total_raw) ? '0 : (total_raw - penalty);
      clamp_hi   = (total_net > SCORE_MAX);
      next_score = clamp_hi ? '1 : total_net[SCORE_W-1:0];
   end

   // State register plus both pipeline stages. start clears the session and
   // drops whatever is still in stage 1, so no stale add can land afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         combo      <= '0;
         max_combo  <= '0;
         multiplier <= 5'd1;
         score      <= '0;
         score_sat  <= 1'b0;
         s1_valid   <= 1'b0;
         s1_sum     <= '0;
         s1_miss    <= '0;
      end else begin
         state <= next_state;
         if (start) begin
            combo      <= '0;
            max_combo  <= '0;
            multiplier <= 5'd1;
            score      <= '0;
            score_sat  <= 1'b0;
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s1_miss    <= '0;
         end else begin
            s1_valid <= accept;
            if (accept) begin
               combo      <= chain_combo;
               max_combo  <= (chain_max > max_combo) ? chain_max : max_combo;
               multiplier <= chain_mult;
               s1_sum     <= chain_sum;
               s1_miss    <= chain_miss;
            end
            if (s1_valid) begin
               score <= next_score;
               if (clamp_hi) score_sat <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_score_engine.sv
// ---------------------------------------------------------------------------
// tb_score_engine
// Self-checking bench for score_engine: directed scenarios plus randomized
// traffic, every cycle compared against an integer reference model of the
// scoring rules. Honours SCORE_MISS_PENALTY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_score_engine;

   localparam int LANES = 4;
   localparam int SMAX  = 65535;
   localparam int CMAX  = 255;
`ifdef SCORE_MISS_PENALTY_EN
   localparam int PEN = 32;
`else
   localparam int PEN = 0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic [LANES-1:0]   hit_valid = '0;
   logic [2*LANES-1:0] hit_grade = '0;
   logic [15:0]        score;
   logic [7:0]         combo, max_combo;
   logic [4:0]         multiplier;
   logic               score_sat, playing, done;

   int checks = 0;
   int failures = 0;

   // Reference model: session phase 0 idle, 1 play, 2 drain, 3 done.
   int m_phase = 0, m_score = 0, m_combo = 0, m_max = 0, m_mult = 1, m_sat = 0;
   int p_valid = 0, p_add = 0, p_miss = 0;

   score_engine dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .hit_valid (hit_valid),
      .hit_grade (hit_grade),
      .score     (score),
      .combo     (combo),
      .max_combo (max_combo),
      .multiplier(multiplier),
      .score_sat (score_sat),
      .playing   (playing),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Scoring rules applied at one clock edge with the inputs sampled there.
   task automatic modelStep(input logic st, input logic sp, input logic rs,
                            input logic [LANES-1:0] hv, input logic [2*LANES-1:0] hg);
      int t;
      int g;
      int had_pending;
      if (rs) begin
         m_phase = 0; m_score = 0; m_combo = 0; m_max = 0; m_mult = 1; m_sat = 0;
         p_valid = 0;
      end else if (st) begin
         m_phase = 1; m_score = 0; m_combo = 0; m_max = 0; m_mult = 1; m_sat = 0;
         p_valid = 0;
      end else begin
         had_pending = p_valid;
         if (p_valid != 0) begin
            t = m_score + p_add - PEN * p_miss;
            if (t < 0) t = 0;
            if (t > SMAX) begin
               t = SMAX;
               m_sat = 1;
            end
            m_score = t;
         end
         p_valid = 0;
         if (m_phase == 1 && !sp) begin
            p_valid = 1; p_add = 0; p_miss = 0;
            for (int i = 0; i < LANES; i++) begin
               if (hv[i]) begin
                  g = int'(hg[2*i +: 2]);
                  if (g == 0) begin
                     m_combo = 0;
                     p_miss++;
                  end else begin
                     m_combo = (m_combo + 1 > CMAX) ? CMAX : m_combo + 1;
                     m_mult = 2 + (m_combo - 1) / 16;
                     if (m_mult > 17) m_mult = 17;
                     p_add += ((g == 3) ? 256 : 32) * m_mult;
                     if (m_combo > m_max) m_max = m_combo;
                  end
               end
            end
         end
         if (m_phase == 1 && sp) m_phase = 2;
         else if (m_phase == 2 && had_pending == 0) m_phase = 3;
      end
   endtask

   task automatic compareAll();
      checkOutput("score", 32'(score), 32'(m_score));
      checkOutput("combo", 32'(combo), 32'(m_combo));
      checkOutput("max_combo", 32'(max_combo), 32'(m_max));
      checkOutput("multiplier", 32'(multiplier), 32'(m_mult));
      checkOutput("score_sat", 32'(score_sat), 32'(m_sat));
      checkOutput("playing", 32'(playing), (m_phase == 1) ? 32'd1 : 32'd0);
      checkOutput("done", 32'(done), (m_phase == 3) ? 32'd1 : 32'd0);
   endtask

   // Drive one cycle on the falling edge, let the DUT and the model take the
   // rising edge, then compare on the next falling edge.
   task automatic applyStimulus(input logic st, input logic sp, input logic rs,
                                input logic [LANES-1:0] hv, input logic [2*LANES-1:0] hg);
      start = st; stop = sp; reset = rs; hit_valid = hv; hit_grade = hg;
      @(posedge clk);
      modelStep(st, sp, rs, hv, hg);
      @(negedge clk);
      compareAll();
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic hitLane0(input logic [1:0] grade, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, {6'b0, grade});
   endtask

   task automatic startSession();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [LANES-1:0]   rhv;
      logic [2*LANES-1:0] rhg;
      int                 exp_mixed;

      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
      checkOutput("rst_mult", 32'(multiplier), 32'd1);
      checkOutput("rst_score", 32'(score), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);

      // Single PERFECT: combo/multiplier one cycle later, score one more.
      startSession();
      checkOutput("start_playing", 32'(playing), 32'd1);
      hitLane0(2'b11, 1);
      checkOutput("pf_combo", 32'(combo), 32'd1);
      checkOutput("pf_mult", 32'(multiplier), 32'd2);
      checkOutput("pf_score_early", 32'(score), 32'd0);
      idleCycle();
      checkOutput("pf_score", 32'(score), 32'd512);

      // 17 GOOD_EARLY crosses into the second tier on the last hit.
      startSession();
      checkOutput("restart_score", 32'(score), 32'd0);
      hitLane0(2'b01, 17);
      idleCycle();
      checkOutput("ge17_combo", 32'(combo), 32'd17);
      checkOutput("ge17_mult", 32'(multiplier), 32'd3);
      checkOutput("ge17_score", 32'(score), 32'd1120);

      // Four PERFECT lanes starting from combo 15 straddle a tier boundary.
      startSession();
      hitLane0(2'b11, 15);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, 8'hFF);
      checkOutput("quad_combo", 32'(combo), 32'd19);
      checkOutput("quad_mult", 32'(multiplier), 32'd3);
      idleCycle();
      checkOutput("quad_score", 32'(score), 32'd10496);

      // MISS in the middle lane: combo restarts, max keeps the peak.
      startSession();
      hitLane0(2'b11, 5);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0111, 8'h33);
      checkOutput("mix_combo", 32'(combo), 32'd1);
      checkOutput("mix_max", 32'(max_combo), 32'd6);
      checkOutput("mix_mult", 32'(multiplier), 32'd2);
      idleCycle();
      exp_mixed = 5 * 512 + 1024 - PEN;
      checkOutput("mix_score", 32'(score), 32'(exp_mixed));

      // Saturation and stickiness of score_sat.
      startSession();
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, 8'hFF);
      idleCycle();
      checkOutput("sat_score", 32'(score), 32'd65535);
      checkOutput("sat_flag", 32'(score_sat), 32'd1);
      hitLane0(2'b01, 3);
      idleCycle();
      checkOutput("sat_hold", 32'(score), 32'd65535);

      // stop right after a hit: the hit still lands, hits on the stop cycle
      // are ignored, done rises one cycle later.
      startSession();
      hitLane0(2'b11, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 8'hFF);
      checkOutput("drain_score", 32'(score), 32'd512);
      checkOutput("drain_combo", 32'(combo), 32'd1);
      checkOutput("drain_done_early", 32'(done), 32'd0);
      idleCycle();
      checkOutput("drain_done", 32'(done), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, 8'hFF);
      checkOutput("done_ignores_hits", 32'(combo), 32'd1);

      // Reset with a hit in flight: nothing ever lands.
      startSession();
      hitLane0(2'b11, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 8'hFF);
      checkOutput("rst_mid_combo", 32'(combo), 32'd0);
      idleCycle();
      idleCycle();
      checkOutput("rst_mid_score", 32'(score), 32'd0);

      // start and stop together: start wins.
      applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
      checkOutput("start_wins", 32'(playing), 32'd1);

      // Randomized traffic with occasional session control.
      for (int n = 0; n < 600; n++) begin
         rhv = LANES'($urandom);
         for (int i = 0; i < LANES; i++)
            rhg[2*i +: 2] = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 199) < 1) ? 1'b1 : 1'b0,
                       rhv, rhg);
         if (m_phase != 1 && $urandom_range(0, 3) == 0) startSession();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/score_engine.md
Name: score_engine

Overview:
- Multi-lane rhythm-game scoring engine: accepts per-lane hit judgements, maintains combo/max-combo internally, applies a tiered combo multiplier and accumulates a saturating score.
- Sits between the lane judgement logic and the score/combo display driver on the LED matrix.
- Successor to the single-input score counter: parametrised lanes, widths and tiers; adds internal combo tracking, a game-session FSM and a 2-stage pipeline.

Parameters:
- LANES, 4, number of judgement lanes processed per cycle (1..8)
- SCORE_W, 16, score width; saturates at 2^SCORE_W-1
- COMBO_W, 8, combo/max_combo width; saturates at 2^COMBO_W-1
- TIER_SHIFT, 4, log2 of combo hits per multiplier tier (16 hits/tier)
- MAX_MULT, 17, multiplier ceiling
- PTS_GOOD, 32, base points for grade GOOD_EARLY/GOOD_LATE
- PTS_PERFECT, 256, base points for grade PERFECT

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: clear session and enter PLAY
- stop  in  1  pulse: end session (drains pipeline)
- hit_valid  in  LANES  per-lane judgement strobe
- hit_grade  in  2*LANES  per-lane grade, lane i at [2i+1:2i]: 00 MISS, 01 GOOD_EARLY, 10 GOOD_LATE, 11 PERFECT
- score  out  SCORE_W  accumulated score
- combo  out  COMBO_W  current combo
- max_combo  out  COMBO_W  highest combo this session
- multiplier  out  5  multiplier applied to the most recent hit
- score_sat  out  1  sticky: score has saturated this session
- playing  out  1  FSM in PLAY
- done  out  1  FSM in DONE (pipeline drained)

Behaviour:
- Reset (synchronous, active-high, in any state incl. mid-pipeline): FSM=IDLE, all outputs 0, multiplier=1, pipeline valid bits cleared.
- FSM: IDLE -start-> PLAY; PLAY -stop-> DRAIN; DRAIN -(after 2 cycles, pipeline empty)-> DONE; DONE -start-> PLAY. start in PLAY/DRAIN restarts: clear score/combo/max_combo/score_sat/multiplier(=1), discard in-flight adds, enter PLAY. start and stop same cycle: start wins.
- hit_valid ignored outside PLAY (including the cycle stop is sampled).
- Lane order: within a cycle lanes processed 0..LANES-1 as a combinational chain; each lane sees combo as left by the previous lane.
- Per valid lane: MISS -> combo=0, add 0. Non-miss -> combo=min(combo+1, 2^COMBO_W-1); mult = combo==0 ? 1 : min(2 + ((combo-1)>>TIER_SHIFT), MAX_MULT) using post-increment combo; add = base_pts*mult.
- Stage 1 (1 cycle after hit): combo, max_combo=max(max_combo, every intermediate combo in chain), multiplier (last non-miss lane; unchanged if none) registered; lane adds summed into an internal register of width SCORE_W+log2(LANES)+5 (no overflow).
- Stage 2 (2 cycles after hit): score = min(score+sum, 2^SCORE_W-1); score_sat set when clamped, sticky until start/reset.
- Back-to-back hits every cycle supported; no stalls.

Optional Feature:
- SCORE_MISS_PENALTY_EN: when defined, each MISS lane subtracts PTS_GOOD (unmultiplied) in stage 2; net per cycle = score + adds - penalties, floored at 0, then clamped high. When undefined, MISS only breaks combo; score never decreases within a session.

Decomposition:
- Package score_pkg: grade encoding constants (GRADE_MISS/GOOD_EARLY/GOOD_LATE/PERFECT), FSM state encoding, function for base points by grade and function for tiered multiplier.
- One sub-module: score_combo_chain (combinational per-lane combo/multiplier/add chain, parametrised by LANES); score_engine holds FSM, pipeline registers and accumulator.

Test Plan:
- reset, start, lane0 PERFECT at cycle T -> combo=1, multiplier=2 at T+1; score=512 at T+2.
- 17 consecutive single-lane GOOD_EARLY hits -> combo=17, multiplier=3, score=16*64+96=1120.
- combo=15, all 4 lanes PERFECT same cycle -> adds 512+768+768+768, score +2816, combo=19, multiplier=3.
- combo=5, lanes0,2 PERFECT, lane1 MISS same cycle -> score +1024, combo=1, max_combo=6, multiplier=2.
- score=65000, lane0 PERFECT at combo 0 -> score=65535, score_sat=1; further hits keep 65535.
- hit at T, stop at T+1 -> score updated at T+2, done=1 at T+3; reset at T+1 instead -> score=0, no update ever lands.
